// File: rtl/obstacle_lane_scheduler.sv
// ----------------------------------------------------------------------------
// obstacle_lane_scheduler
//
// Purpose
//   Paces obstacle-lane motion for the road game. A score-driven base tick is
//   divided per lane into one-cycle step strobes. The block also owns the
//   IDLE / RUN / FREEZE / CRASH game state and the per-lane direction bits.
//   The car position datapath moves a car only on its lane's strobe.
//
// Parameters
//   C_BASE_TICK     base tick period in clocks at tier 0 (20-bit)
//   NUM_LANES       number of lanes (1..8)
//   C_LANE_DIV      2 bits per lane (lane0 = LSBs); lane steps every d+1 ticks
//   C_REVERSE_MASK  lanes whose direction toggles on each tier increase
//   C_FREEZE_TICKS  base ticks spent in FREEZE after a tier increase (8-bit)
//
// Ports
//   i_Clk        in   1          system clock
//   i_Rst_L      in   1          asynchronous active-low reset
//   i_Start      in   1          pulse: start / restart a run
//   i_Crash      in   1          pulse: player hit, stop lanes
//   i_Score      in   4          current score 0..15
//   o_Lane_Step  out  NUM_LANES  one-cycle step strobe per lane
//   o_Reverse    out  NUM_LANES  lane direction, 1 = right-to-left
//   o_Tier       out  2          current difficulty tier
//   o_Running    out  1          high in RUN only
//   o_Frozen     out  1          high in FREEZE only
//   o_State      out  2          debug: FSM state (0 IDLE, 1 RUN, 2 FREEZE, 3 CRASH)
//
// Configuration macro
//   RANDOM_REVERSE_EN  when defined, the tier-increase direction toggle comes
//                      from an 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5,
//                      advanced every base tick) instead of C_REVERSE_MASK.
//                      An all-zero LFSR slice falls back to C_REVERSE_MASK.
// ----------------------------------------------------------------------------
module obstacle_lane_scheduler #(
    parameter int unsigned  C_BASE_TICK    = 781250,
    parameter int unsigned  NUM_LANES      = 4,
    parameter logic [15:0]  C_LANE_DIV     = 16'h00E4,
    parameter logic [7:0]   C_REVERSE_MASK = 8'h0A,
    parameter int unsigned  C_FREEZE_TICKS = 16
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_L,
    input  logic                 i_Start,
    input  logic                 i_Crash,
    input  logic [3:0]           i_Score,
    output logic [NUM_LANES-1:0] o_Lane_Step,
    output logic [NUM_LANES-1:0] o_Reverse,
    output logic [1:0]           o_Tier,
    output logic                 o_Running,
    output logic                 o_Frozen,
    output logic [1:0]           o_State
);

    localparam logic [19:0] BASE_TICK    = 20'(C_BASE_TICK);
    localparam logic [8:0]  FREEZE_TICKS = 9'(C_FREEZE_TICKS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FREEZE = 2'd2,
        S_CRASH  = 2'd3
    } state_t;

    state_t                   state;
    logic [19:0]              base_cnt;
    logic [19:0]              period;
    logic [7:0]               freeze_cnt;
    logic [2*NUM_LANES-1:0]   presc;

    logic [1:0]               tier_calc;
    logic [1:0]               tier_next;
    logic                     active;
    logic                     tick;
    logic                     tier_up;
    logic                     tier_down;
    logic                     step_fire;
    logic [NUM_LANES-1:0]     rev_mask;

    // Base tick period for a tier; never allowed to collapse to zero.
    function automatic logic [19:0] period_of(input logic [1:0] tier);
        logic [19:0] p;
        p = BASE_TICK >> tier;
        if (p == 20'd0) begin
            p = 20'd1;
        end
        return p;
    endfunction

    always_comb begin
        tier_calc = 2'd0;
        if (i_Score >= 4'd10) begin
            tier_calc = 2'd3;
        end else if (i_Score >= 4'd7) begin
            tier_calc = 2'd2;
        end else if (i_Score >= 4'd4) begin
            tier_calc = 2'd1;
        end
    end

    assign active = (state == S_RUN) || (state == S_FREEZE);
    assign tick   = active && (base_cnt >= (period - 20'd1));

    // Crash has priority over everything else, so a crash cycle neither
    // raises the tier nor applies a pending decrease.
    assign tier_up   = (state == S_RUN) && !i_Crash && (tier_calc > o_Tier);
    assign tier_down = tick && !i_Crash && (tier_calc < o_Tier);

    always_comb begin
        tier_next = o_Tier;
        if (tier_up || tier_down) begin
            tier_next = tier_calc;
        end
    end

    // Strobes only come from ticks that keep the FSM in RUN; a tick on the
    // cycle that leaves RUN is dropped and the prescalers hold.
    assign step_fire = tick && (state == S_RUN) && !i_Crash && !tier_up;

`ifdef RANDOM_REVERSE_EN
    logic [7:0]           lfsr;
    logic [NUM_LANES-1:0] lfsr_slice;

    assign lfsr_slice = lfsr[NUM_LANES-1:0];
    assign rev_mask   = (lfsr_slice != '0) ? lfsr_slice : C_REVERSE_MASK[NUM_LANES-1:0];

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            lfsr <= 8'hA5;
        end else if (tick && !i_Crash) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end
`else
    assign rev_mask = C_REVERSE_MASK[NUM_LANES-1:0];
`endif

    assign o_State = state;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state       <= S_IDLE;
            base_cnt    <= 20'd0;
            period      <= period_of(2'd0);
            freeze_cnt  <= 8'd0;
            presc       <= '0;
            o_Lane_Step <= '0;
            o_Reverse   <= '0;
            o_Tier      <= 2'd0;
            o_Running   <= 1'b0;
            o_Frozen    <= 1'b0;
        end else begin
            o_Lane_Step <= '0;

            // Base tick counter; a new period only takes effect at the wrap
            // so the running period is never cut short.
            if (active && !i_Crash) begin
                o_Tier <= tier_next;
                if (tick) begin
                    base_cnt <= 20'd0;
                    period   <= period_of(tier_next);
                end else begin
                    base_cnt <= base_cnt + 20'd1;
                end
            end

            if (step_fire) begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    if (presc[2*i +: 2] == C_LANE_DIV[2*i +: 2]) begin
                        presc[2*i +: 2] <= 2'd0;
                        o_Lane_Step[i]  <= 1'b1;
                    end else begin
                        presc[2*i +: 2] <= presc[2*i +: 2] + 2'd1;
                    end
                end
            end

            case (state)
                S_IDLE, S_CRASH: begin
                    if (i_Start && !i_Crash) begin
                        state      <= S_RUN;
                        o_Running  <= 1'b1;
                        o_Frozen   <= 1'b0;
                        base_cnt   <= 20'd0;
                        period     <= period_of(tier_calc);
                        freeze_cnt <= 8'd0;
                        presc      <= '0;
                        o_Tier     <= tier_calc;
                        o_Reverse  <= '0;
                    end
                end

                S_RUN: begin
                    if (i_Crash) begin
                        state     <= S_CRASH;
                        o_Running <= 1'b0;
                    end else if (tier_up) begin
                        // A multi-level jump still gives one freeze and one toggle.
                        state      <= S_FREEZE;
                        o_Running  <= 1'b0;
                        o_Frozen   <= 1'b1;
                        freeze_cnt <= 8'd0;
                        o_Reverse  <= o_Reverse ^ rev_mask;
                    end
                end

                S_FREEZE: begin
                    if (i_Crash) begin
                        state    <= S_CRASH;
                        o_Frozen <= 1'b0;
                    end else if (tick) begin
                        if (({1'b0, freeze_cnt} + 9'd1) >= FREEZE_TICKS) begin
                            state      <= S_RUN;
                            o_Running  <= 1'b1;
                            o_Frozen   <= 1'b0;
                            freeze_cnt <= 8'd0;
                        end else begin
                            freeze_cnt <= freeze_cnt + 8'd1;
                        end
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    o_Running <= 1'b0;
                    o_Frozen  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_obstacle_lane_scheduler.sv
// ----------------------------------------------------------------------------
// tb_obstacle_lane_scheduler
//
// Directed bench for obstacle_lane_scheduler with C_BASE_TICK=16 and
// C_FREEZE_TICKS=2. Expected strobe times are hand-derived from the tick
// period and the per-lane divider (E4 -> d = 0,1,2,3 for lanes 0..3).
// Time t counts clock edges since the most recent start edge (t=0).
// ----------------------------------------------------------------------------
module tb_obstacle_lane_scheduler;

    localparam int NL = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          crash;
    logic [3:0]    score;
    logic [NL-1:0] lane_step;
    logic [NL-1:0] reverse;
    logic [1:0]    tier;
    logic          running;
    logic          frozen;
    logic [1:0]    state;

    int total = 0;
    int bad   = 0;
    int t     = 0;

    int first_t  [NL];
    int second_t [NL];
    int cnt_s    [NL];
    int frz_cyc;

    logic [3:0] exp_rev;

    obstacle_lane_scheduler #(
        .C_BASE_TICK    (16),
        .NUM_LANES      (NL),
        .C_FREEZE_TICKS (2)
    ) dut (
        .i_Clk       (clk),
        .i_Rst_L     (rst_n),
        .i_Start     (start),
        .i_Crash     (crash),
        .i_Score     (score),
        .o_Lane_Step (lane_step),
        .o_Reverse   (reverse),
        .o_Tier      (tier),
        .o_Running   (running),
        .o_Frozen    (frozen),
        .o_State     (state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // ---------------- reference LFSR ----------------
    function automatic logic [7:0] lfsr_after(input int n);
        logic [7:0] l;
        l = 8'hA5;
        for (int k = 0; k < n; k++) begin
            l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        end
        return l;
    endfunction

    function automatic logic [3:0] toggle_mask(input int ticks);
        logic [3:0] s;
`ifdef RANDOM_REVERSE_EN
        logic [7:0] l;
        l = lfsr_after(ticks);
        s = l[3:0];
        if (s == 4'd0) begin
            s = 4'b1010;
        end
`else
        s = 4'b1010;
        if (ticks < 0) begin
            s = 4'd0;
        end
`endif
        return s;
    endfunction

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic run_rec(input int n);
        for (int i = 0; i < NL; i++) begin
            first_t[i]  = -1;
            second_t[i] = -1;
            cnt_s[i]    = 0;
        end
        frz_cyc = 0;
        repeat (n) begin
            step();
            for (int i = 0; i < NL; i++) begin
                if (lane_step[i] === 1'b1) begin
                    cnt_s[i]++;
                    if (first_t[i] < 0) first_t[i] = t;
                    else if (second_t[i] < 0) second_t[i] = t;
                end
            end
            if (frozen === 1'b1) frz_cyc++;
        end
    endtask

    function automatic int all_steps();
        int s;
        s = 0;
        for (int i = 0; i < NL; i++) s += cnt_s[i];
        return s;
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        crash = 1'b0;
        score = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_step",    32'(lane_step), 0);
        check("rst_reverse", 32'(reverse),   0);
        check("rst_tier",    32'(tier),      0);
        check("rst_running", 32'(running),   0);
        check("rst_frozen",  32'(frozen),    0);
        check("rst_state",   32'(state),     0);
        rst_n = 1'b1;
        step();
        step();
        check("idle_hold", 32'(state), 0);

        // 1: tier 0 run, P = 16
        start = 1'b1;
        step();
        start = 1'b0;
        t = 0;
        check("t1_running", 32'(running), 1);
        check("t1_state",   32'(state),   1);
        run_rec(130);
        check("t1_l0_first",  32'(first_t[0]),  16);
        check("t1_l0_second", 32'(second_t[0]), 32);
        check("t1_l0_count",  32'(cnt_s[0]),    8);
        check("t1_l1_first",  32'(first_t[1]),  32);
        check("t1_l2_first",  32'(first_t[2]),  48);
        check("t1_l3_first",  32'(first_t[3]),  64);
        check("t1_l3_second", 32'(second_t[3]), 128);
        check("t1_l3_count",  32'(cnt_s[3]),    2);

        // 2: tier increase -> FREEZE for 2 ticks, then P = 8
        score = 4'd4;
        step();
        exp_rev = toggle_mask(8);
        check("t2_frozen",  32'(frozen),  1);
        check("t2_running", 32'(running), 0);
        check("t2_tier",    32'(tier),    1);
        check("t2_reverse", 32'(reverse), 32'(exp_rev));
        run_rec(21);
        check("t2_frz_cycles",   32'(frz_cyc),     20);
        check("t2_frz_nosteps",  32'(all_steps()), 0);
        check("t2_resume",       32'(running),     1);
        run_rec(40);
        check("t2_l0_first",  32'(first_t[0]),  160);
        check("t2_l0_second", 32'(second_t[0]), 168);
        check("t2_l3_hold",   32'(first_t[3]),  184);

        // 3: crash beats tier increase, then restart
        score = 4'd6;
        step();
        crash = 1'b1;
        score = 4'd7;
        step();
        crash = 1'b0;
        check("t3_state",   32'(state),   3);
        check("t3_tier",    32'(tier),    1);
        check("t3_running", 32'(running), 0);
        run_rec(20);
        check("t3_nosteps", 32'(all_steps()), 0);
        start = 1'b1;
        crash = 1'b1;
        step();
        crash = 1'b0;
        check("t3_crash_beats_start", 32'(state), 3);
        step();
        start = 1'b0;
        t = 0;
        check("t3_restart_run", 32'(running), 1);
        check("t3_restart_rev", 32'(reverse), 0);
        check("t3_restart_tier", 32'(tier),   2);
        check("t3_restart_frz", 32'(frozen),  0);
        run_rec(12);
        check("t3_l0_first",  32'(first_t[0]),  4);
        check("t3_l0_second", 32'(second_t[0]), 8);
        check("t3_l0_count",  32'(cnt_s[0]),    3);
        start = 1'b1;
        step();
        start = 1'b0;
        run_rec(7);
        check("t3_start_ignored", 32'(first_t[0]), 16);
        check("t3_start_ignored2", 32'(second_t[0]), 20);

        // 4: decrease at next tick without freeze, then 0 -> 10 jump
        score = 4'd0;
        run_rec(6);
        check("t4_dec_tier",   32'(tier),    0);
        check("t4_dec_nofrz",  32'(frz_cyc), 0);
        check("t4_dec_rev",    32'(reverse), 0);
        score = 4'd10;
        step();
        check("t4_frozen", 32'(frozen), 1);
        check("t4_tier",   32'(tier),   3);
        run_rec(30);
        check("t4_frz_cycles", 32'(frz_cyc),     14);
        check("t4_l0_first",   32'(first_t[0]),  44);
        check("t4_l0_second",  32'(second_t[0]), 46);
        check("t4_running",    32'(running),     1);
        check("t4_tier_end",   32'(tier),        3);
`ifndef RANDOM_REVERSE_EN
        check("t4_single_toggle", 32'(reverse), 'hA);
`endif

        // 5: async reset in the middle of FREEZE
        score = 4'd0;
        step();
        step();
        step();
        check("t5_dec_tier", 32'(tier), 0);
        score = 4'd4;
        step();
        check("t5_frozen", 32'(frozen), 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_async_frozen",  32'(frozen),    0);
        check("t5_async_tier",    32'(tier),      0);
        check("t5_async_reverse", 32'(reverse),   0);
        check("t5_async_state",   32'(state),     0);
        check("t5_async_step",    32'(lane_step), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        check("t5_idle_after", 32'(state), 0);
        start = 1'b1;
        crash = 1'b1;
        step();
        start = 1'b0;
        crash = 1'b0;
        check("t5_idle_crash_beats_start", 32'(state), 0);

        // 6: first toggle after one tick (LFSR slice or fixed mask)
        score = 4'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        t = 0;
        run_rec(20);
        score = 4'd4;
        step();
        exp_rev = toggle_mask(1);
        check("t6_reverse", 32'(reverse), 32'(exp_rev));
        check("t6_nonzero", 32'(reverse != 4'd0), 1);
        check("t6_tier",    32'(tier), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
